arb_requester: RTL and testbench
================================

Name: arb_requester

Overview:
- Client-side companion of the combinational round-robin arbiter: the "other end" of the reqs/lowp/grant interface.
- Captures single-cycle request pulses from 8 clients into a pending register and drives them to the arbiter as reqs_o.
- Consumes the arbiter's winner index, acks the winning client, holds the shared resource until done or timeout, then rotates the low-priority pointer (lowp_o) fed back to the arbiter.

Parameters:
- N_REQ, 8, number of clients (fixed 8 for the arbiter interface)
- IDX_W, 3, width of client index, log2(N_REQ)
- MAX_HOLD, 15, max SERVE cycles before forced release (1..15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_pulse_i  in  8  per-client request pulses; bit i high one cycle = client i requests
- done_i  in  1  resource finished serving current client (sampled only in SERVE)
- grant_idx_i  in  3  winner index from arbiter
- any_grant_i  in  1  arbiter reports at least one request
- reqs_o  out  8  pending request vector to arbiter (registered)
- lowp_o  out  3  lowest-priority index to arbiter (registered)
- ack_o  out  8  one-hot ack to winning client, one-cycle pulse
- owner_o  out  3  index of client currently holding resource
- busy_o  out  1  high while in SERVE
- pending_cnt_o  out  4  popcount of reqs_o, 0..8
- dup_o  out  1  one-cycle pulse: a pulse hit an already-pending bit
- timeout_o  out  1  one-cycle pulse: SERVE ended by MAX_HOLD, not done_i

Behaviour:
- Reset values: reqs_o=0, lowp_o=3'd7 (client 0 searched first), ack_o=0, owner_o=0, busy_o=0, pending_cnt_o=0, dup_o=0, timeout_o=0, state=IDLE, hold counter=0.
- Reset mid-SERVE drops everything: pending requests are lost and no ack or timeout is emitted.
- Pending capture:
  - reqs_o[i] sets on the edge after req_pulse_i[i]=1.
  - A pulse on an already-set bit is merged; dup_o pulses next cycle.
  - Multiple bits may pulse in the same cycle; each sets independently.
- FSM states: IDLE, SERVE.
- IDLE:
  - At an edge with any_grant_i=1 and reqs_o!=0: latch owner_o=grant_idx_i, clear reqs_o[grant_idx_i], set ack_o=one-hot(grant_idx_i) for one cycle, busy_o=1, go to SERVE.
  - If any_grant_i=1 but reqs_o==0, or reqs_o[grant_idx_i]==0 (inconsistent arbiter), ignore and stay in IDLE.
- SERVE:
  - The hold counter increments each cycle.
  - done_i=1 (sampled from the first SERVE cycle): go to IDLE, lowp_o<=owner_o, busy_o=0, counter=0.
  - Otherwise, when counter==MAX_HOLD-1: same exit, plus timeout_o pulse.
  - done_i in IDLE is ignored.
- Latency: pulse at edge k -> reqs_o at k+1 -> ack_o high during cycle after edge k+2 (IDLE sample).
  - Minimum grant-to-grant spacing is 2 cycles (one SERVE cycle with done_i, one IDLE cycle).
- Simultaneous events:
  - A pulse on the bit being cleared at the grant edge keeps the bit set: a new request wins over the clear. No dup_o.
  - Pulses during SERVE, including from owner_o, are captured normally; owner_o can be re-granted later.
- Rotation: lowp_o=w after serving w, so the arbiter searches w+1..7, 0..w. Wrap-around: w=7 gives lowp_o=7, so search starts at 0.
- Width rules:
  - pending_cnt_o is a 4-bit popcount of registered reqs_o; all 8 set gives 4'd8.
  - The hold counter is 4 bits, saturating never needed (MAX_HOLD<=15).

Decomposition:
- Package arb_pkg: N_REQ, IDX_W, CNT_W=4, typedef logic[IDX_W-1:0] idx_t, typedef logic[N_REQ-1:0] req_vec_t, enum {IDLE, SERVE} req_state_t, function onehot(idx_t).
- No sub-module needed. For integration bench, instantiate with the existing arbiter in a top wrapper arb_subsys.

Test Plan:
- Reset: assert rst mid-SERVE with reqs_o=8'hA5 -> all outputs to reset values asynchronously, lowp_o=7, no ack after release.
- Single request: pulse bit 3, done_i one cycle after ack -> ack_o=8'h08 exactly once, owner_o=3, lowp_o=3 after exit, reqs_o=0, pending_cnt_o 1->0.
- Round-robin fairness: pulse 8'hFF at once, done_i every SERVE's first cycle -> ack order 0,1,...,7, pending_cnt_o counts 8..0, final lowp_o=7.
- Timeout: pulse bit 5, never assert done_i -> busy_o high exactly 15 cycles, timeout_o one pulse, lowp_o=5.
- Duplicate and re-request collision: pulse bit 2 twice while pending -> one dup_o, single ack. Pulse bit 6 on its grant edge -> ack_o=8'h40 and reqs_o[6] stays 1, second ack for 6 later.
- Wrap: lowp_o=6 with reqs 8'h81 -> grant order 7 then 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter client side.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: client count and index width, the pending/ack vector type,
// the requester FSM state type and a one-hot decode helper.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] req_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } req_state_t;

  function automatic req_vec_t onehot(input idx_t idx);
    onehot = req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/arb_requester_if.sv
// Bus between the requester and the combinational round-robin arbiter.
// Latency: purely wires; the arbiter answers in the same cycle.
// Backpressure: none; the requester simply ignores an inconsistent grant.
//
// Signals:
//   reqs      : pending request vector, requester -> arbiter
//   lowp      : lowest-priority client index, requester -> arbiter
//   grant_idx : winner index, arbiter -> requester
//   any_grant : arbiter saw at least one request, arbiter -> requester
interface arb_requester_if;
  import arb_pkg::*;

  req_vec_t reqs;
  idx_t     lowp;
  idx_t     grant_idx;
  logic     any_grant;

  // Requester side.
  modport master (
    output reqs,
    output lowp,
    input  grant_idx,
    input  any_grant
  );

  // Arbiter side.
  modport slave (
    input  reqs,
    input  lowp,
    output grant_idx,
    output any_grant
  );

endinterface

// File: rtl/arb_requester.sv
// Client-side companion of the round-robin arbiter: collects request pulses,
// acks the winner, holds the resource until done or MAX_HOLD, then rotates lowp.
// Latency: pulse sampled at edge k -> pending at k+1 -> ack after edge k+2.
// Backpressure: requests arriving while serving stay pending until a later grant.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_pulse_i     : per-client single-cycle request pulses
//   done_i          : resource finished with the current owner (SERVE only)
//   arb_if          : reqs/lowp out to the arbiter, grant_idx/any_grant back
//   ack_o           : one-hot, one-cycle ack to the winning client
//   owner_o         : client currently holding the resource
//   busy_o          : high while serving
//   pending_cnt_o   : number of pending requests (0..8)
//   dup_o           : pulse, a request hit an already-pending bit
//   timeout_o       : pulse, service ended by MAX_HOLD instead of done_i
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  req_vec_t           req_pulse_i,
  input  logic               done_i,
  arb_requester_if.master    arb_if,
  output req_vec_t           ack_o,
  output idx_t               owner_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   pending_cnt_o,
  output logic               dup_o,
  output logic               timeout_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  req_state_t       state_q, state_d;
  req_vec_t         reqs_q, reqs_d;
  idx_t             lowp_q, lowp_d;
  idx_t             owner_q, owner_d;
  req_vec_t         ack_q, ack_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             dup_q, dup_d;
  logic             timeout_q, timeout_d;
  req_vec_t         clr_mask;
  logic [CNT_W-1:0] pend_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      reqs_q    <= '0;
      lowp_q    <= '1;  // lowp=7 makes client 0 the first searched
      owner_q   <= '0;
      ack_q     <= '0;
      hold_q    <= '0;
      dup_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reqs_q    <= reqs_d;
      lowp_q    <= lowp_d;
      owner_q   <= owner_d;
      ack_q     <= ack_d;
      hold_q    <= hold_d;
      dup_q     <= dup_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lowp_d    = lowp_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    ack_d     = '0;
    timeout_d = 1'b0;
    clr_mask  = '0;

    case (state_q)
      IDLE: begin
        // Only accept a grant that points at a bit we actually have pending;
        // this also covers any_grant with an empty vector.
        if (arb_if.any_grant && reqs_q[arb_if.grant_idx]) begin
          clr_mask = onehot(arb_if.grant_idx);
          owner_d  = arb_if.grant_idx;
          ack_d    = onehot(arb_if.grant_idx);
          hold_d   = '0;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (done_i || (hold_q == HOLD_LAST)) begin
          state_d   = IDLE;
          lowp_d    = owner_q;
          hold_d    = '0;
          timeout_d = !done_i;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh pulse on the bit being granted re-arms it rather than merging,
    // so it neither gets lost nor counts as a duplicate.
    reqs_d = (reqs_q & ~clr_mask) | req_pulse_i;
    dup_d  = |(req_pulse_i & reqs_q & ~clr_mask);
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pend_cnt = pend_cnt + CNT_W'(reqs_q[i]);
    end
  end

  assign arb_if.reqs   = reqs_q;
  assign arb_if.lowp   = lowp_q;
  assign ack_o         = ack_q;
  assign owner_o       = owner_q;
  assign busy_o        = (state_q == SERVE);
  assign pending_cnt_o = pend_cnt;
  assign dup_o         = dup_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_arb_requester.sv
`timescale 1ns/1ps
module tb_arb_requester;

  localparam int HOLD = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_pulse = '0;
  logic       done = 1'b0;
  logic       bad = 1'b0;
  logic [2:0] bad_idx = '0;

  logic [7:0] ack;
  logic [2:0] owner;
  logic       busy;
  logic [3:0] pcnt;
  logic       dup;
  logic       tout;

  int nvec = 0;
  int nmis = 0;

  arb_requester_if bus();

  arb_requester #(.MAX_HOLD(HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_pulse_i   (req_pulse),
    .done_i        (done),
    .arb_if        (bus),
    .ack_o         (ack),
    .owner_o       (owner),
    .busy_o        (busy),
    .pending_cnt_o (pcnt),
    .dup_o         (dup),
    .timeout_o     (tout)
  );

  always #5 clk = ~clk;

  // Combinational round-robin arbiter: search lowp+1 .. lowp (wrapping).
  // 'bad' forces an inconsistent grant to exercise the ignore path.
  function automatic logic [2:0] rr_arb(input logic [7:0] r, input logic [2:0] lp);
    logic [2:0] w;
    w = '0;
    for (int k = 8; k >= 1; k--) begin
      if (r[(int'(lp) + k) % 8]) w = 3'((int'(lp) + k) % 8);
    end
    return w;
  endfunction

  assign bus.any_grant = bad | (|bus.reqs);
  assign bus.grant_idx = bad ? bad_idx : rr_arb(bus.reqs, bus.lowp);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_pend[8];
  int         m_owner, m_lowp, m_hold;
  bit         m_serv;
  logic [7:0] m_ack;
  bit         m_dup, m_to;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_owner = 0; m_lowp = 7; m_hold = 0; m_serv = 1'b0;
    m_ack = '0; m_dup = 1'b0; m_to = 1'b0;
  endtask

  function automatic int pick();
    for (int k = 1; k <= 8; k++) begin
      if (m_pend[(m_lowp + k) % 8]) return (m_lowp + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] p, input logic d, input logic b, input logic [2:0] bi);
    int g;
    bit gv;
    m_ack = '0; m_dup = 1'b0; m_to = 1'b0; gv = 1'b0; g = -1;
    if (!m_serv) begin
      g = b ? int'(bi) : pick();
      if (g >= 0 && m_pend[g]) gv = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      if (p[i] && m_pend[i] && !(gv && i == g)) m_dup = 1'b1;
    end
    if (!m_serv) begin
      if (gv) begin
        m_pend[g] = 1'b0; m_owner = g; m_serv = 1'b1; m_hold = 0; m_ack[g] = 1'b1;
      end
    end else if (d || m_hold == HOLD - 1) begin
      m_serv = 1'b0; m_lowp = m_owner; m_to = !d; m_hold = 0;
    end else begin
      m_hold++;
    end
    for (int i = 0; i < 8; i++) if (p[i]) m_pend[i] = 1'b1;
  endtask

  task automatic compare();
    logic [7:0] ev;
    int cnt;
    ev = '0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      ev[i] = m_pend[i];
      cnt += int'(m_pend[i]);
    end
    chk("reqs_o", bus.reqs, ev);
    chk("lowp_o", bus.lowp, m_lowp);
    chk("ack_o", ack, m_ack);
    chk("owner_o", owner, m_owner);
    chk("busy_o", busy, m_serv);
    chk("pending_cnt_o", pcnt, cnt);
    chk("dup_o", dup, m_dup);
    chk("timeout_o", tout, m_to);
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step(req_pulse, done, bad, bad_idx);
    #2;
    compare();
  end

  // ---------------- event monitor ----------------
  int busy_cnt, to_cnt, dup_cnt;
  int ack_log[$];

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (busy) busy_cnt++;
      if (tout) to_cnt++;
      if (dup)  dup_cnt++;
      for (int i = 0; i < 8; i++) if (ack[i]) ack_log.push_back(i);
    end
  end

  task automatic clear_mon();
    busy_cnt = 0; to_cnt = 0; dup_cnt = 0;
    ack_log.delete();
  endtask

  task automatic check_order(input string nm, input int exp[8], input int n);
    chk({nm, "_count"}, ack_log.size(), n);
    for (int i = 0; i < n; i++) begin
      chk(nm, (i < ack_log.size()) ? ack_log[i] : -1, exp[i]);
    end
  endtask

  task automatic drive(input logic [7:0] p, input logic d);
    @(negedge clk);
    req_pulse = p;
    done      = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clear_mon();
    #12;
    chk("rst_reqs", bus.reqs, 8'h00);
    chk("rst_lowp", bus.lowp, 3'd7);
    chk("rst_ack", ack, 8'h00);
    chk("rst_owner", owner, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pcnt", pcnt, 4'd0);
    chk("rst_dup", dup, 1'b0);
    chk("rst_timeout", tout, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // All eight at once: served 0..7 with done on each first SERVE cycle.
    clear_mon();
    drive(8'hFF, 1'b0);
    @(posedge clk); #1;
    chk("fair_pcnt_full", pcnt, 4'd8);
    for (int i = 0; i < 8; i++) begin
      drive(8'h00, 1'b0);
      drive(8'h00, 1'b1);
    end
    drive(8'h00, 1'b0);
    check_order("fair_order", '{0, 1, 2, 3, 4, 5, 6, 7}, 8);
    chk("fair_lowp", bus.lowp, 3'd7);
    chk("fair_pcnt_empty", pcnt, 4'd0);

    // Single request on client 3.
    clear_mon();
    drive(8'h08, 1'b0);
    drive(8'h00, 1'b0);
    @(posedge clk); #1;
    chk("single_ack", ack, 8'h08);
    chk("single_pcnt_after_grant", pcnt, 4'd0);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    check_order("single_order", '{3, 0, 0, 0, 0, 0, 0, 0}, 1);
    chk("single_owner", owner, 3'd3);
    chk("single_lowp", bus.lowp, 3'd3);

    // Client 5 never signals done: forced release after MAX_HOLD cycles.
    // A done in IDLE at the tail must be ignored.
    clear_mon();
    drive(8'h20, 1'b0);
    repeat (20) drive(8'h00, 1'b0);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    chk("to_busy_cycles", busy_cnt, 15);
    chk("to_pulses", to_cnt, 1);
    chk("to_lowp", bus.lowp, 3'd5);

    // Client 2 requests twice while client 0 holds the resource.
    clear_mon();
    drive(8'h01, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h04, 1'b0);
    drive(8'h04, 1'b0);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    chk("dup_pulses", dup_cnt, 1);
    check_order("dup_order", '{0, 2, 0, 0, 0, 0, 0, 0}, 2);
    chk("dup_lowp", bus.lowp, 3'd2);

    // Client 6 re-requests on its own grant edge.
    clear_mon();
    drive(8'h40, 1'b0);
    drive(8'h40, 1'b0);
    @(posedge clk); #1;
    chk("coll_ack", ack, 8'h40);
    chk("coll_reqs_kept", bus.reqs, 8'h40);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    chk("coll_dup", dup_cnt, 0);
    check_order("coll_order", '{6, 6, 0, 0, 0, 0, 0, 0}, 2);
    chk("coll_lowp", bus.lowp, 3'd6);

    // Wrap: lowp=6 with clients 7 and 0 pending.
    clear_mon();
    drive(8'h81, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    check_order("wrap_order", '{7, 0, 0, 0, 0, 0, 0, 0}, 2);
    chk("wrap_lowp", bus.lowp, 3'd0);

    // Arbiter points at a client that is not pending: ignored.
    clear_mon();
    bad = 1'b1;
    bad_idx = 3'd4;
    drive(8'h00, 1'b0);
    drive(8'h02, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    chk("bad_busy", busy, 1'b0);
    chk("bad_reqs", bus.reqs, 8'h02);
    bad = 1'b0;
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    check_order("bad_order", '{1, 0, 0, 0, 0, 0, 0, 0}, 1);

    // Reset while serving with reqs=A5: everything dropped, asynchronously.
    clear_mon();
    drive(8'h01, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'hA5, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_reqs", bus.reqs, 8'hA5);
    chk("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    req_pulse = 8'h00;
    rst = 1'b1;
    #1;
    chk("arst_reqs", bus.reqs, 8'h00);
    chk("arst_lowp", bus.lowp, 3'd7);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ack", ack, 8'h00);
    chk("arst_owner", owner, 3'd0);
    chk("arst_pcnt", pcnt, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (4) drive(8'h00, 1'b0);
    chk("post_rst_acks", ack_log.size(), 0);
    chk("post_rst_timeouts", to_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected under 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
